// File: rtl/fbcpu_mem.sv
// 64x10 single-port program/data memory for the FB-CPU bus, with a post-reset clear
// and a valid/ready program loader that holds the CPU in reset while it owns the port.
module fbcpu_mem #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] MAR,
  input  logic                     RAMWr,
  input  logic [DATA_WIDTH-1:0]    MDRIn,
  output logic [DATA_WIDTH-1:0]    MDROut,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     cpu_rst,
  output logic                     ld_done,
  output logic [ADDRESS_WIDTH:0]   ld_count
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = (ADDRESS_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_LOAD
  } state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] ptr_q;
  logic [ADDRESS_WIDTH:0]   cnt_q;
  logic [ADDRESS_WIDTH:0]   ld_count_q;
  logic                     ld_done_q;
  logic [DATA_WIDTH-1:0]    mdr_q;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     we_d;
  logic [ADDRESS_WIDTH-1:0] wa_d;
  logic [DATA_WIDTH-1:0]    wd_d;
  logic                     last_word;

  // A load also stops after the top address so the pointer never wraps.
  assign last_word = ld_last || (ptr_q == '1);

  always_comb begin
    we_d = 1'b0;
    wa_d = MAR;
    wd_d = MDRIn;
    if (!rst) begin
      unique case (state_q)
        S_CLEAR: begin
          we_d = 1'b1;
          wa_d = ptr_q;
          wd_d = '0;
        end
        S_RUN: we_d = RAMWr;
        S_LOAD: begin
          we_d = ld_valid;
          wa_d = ptr_q;
          wd_d = ld_data;
        end
        default: we_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we_d) mem[wa_d] <= wd_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ld_count_q <= '0;
      ld_done_q  <= 1'b0;
      mdr_q      <= '0;
    end else begin
      ld_done_q <= 1'b0;
      mdr_q     <= '0;
      unique case (state_q)
        S_CLEAR: begin
          ptr_q <= ptr_q + PTR_ONE;
          if (ptr_q == '1) state_q <= S_RUN;
        end
        S_RUN: begin
          // Read data is zeroed on the way into LOAD so the CPU sees nothing while held.
          if (ld_start) begin
            state_q <= S_LOAD;
            ptr_q   <= '0;
            cnt_q   <= '0;
          end else begin
            mdr_q <= mem[MAR];
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            ptr_q <= ptr_q + PTR_ONE;
            cnt_q <= cnt_q + CNT_ONE;
            if (last_word) begin
              state_q    <= S_RUN;
              ld_count_q <= cnt_q + CNT_ONE;
              ld_done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign MDROut   = mdr_q;
  assign ld_ready = (state_q == S_LOAD);
  assign cpu_rst  = (state_q != S_RUN);
  assign ld_done  = ld_done_q;
  assign ld_count = ld_count_q;

endmodule

// File: tb/tb_fbcpu_mem.sv
// Directed bench for fbcpu_mem: reference memory model plus a read scoreboard.
module tb_fbcpu_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] MAR;
  logic       RAMWr;
  logic [9:0] MDRIn;
  logic [9:0] MDROut;
  logic       ld_start;
  logic       ld_valid;
  logic [9:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       cpu_rst;
  logic       ld_done;
  logic [6:0] ld_count;

  int errors = 0;
  int checks = 0;

  logic [9:0] mdl [64];
  logic [9:0] sb [$];

  fbcpu_mem dut (
    .clk      (clk),
    .rst      (rst),
    .MAR      (MAR),
    .RAMWr    (RAMWr),
    .MDRIn    (MDRIn),
    .MDROut   (MDROut),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .ld_done  (ld_done),
    .ld_count (ld_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pipelined read: expected value is queued when MAR is driven, compared one edge later.
  task automatic rd(input logic [5:0] a);
    logic [9:0] e;
    MAR   = a;
    RAMWr = 1'b0;
    sb.push_back(mdl[a]);
    tick();
    e = sb.pop_front();
    chk($sformatf("rd[%0d]", a), {6'd0, MDROut}, {6'd0, e});
  endtask

  task automatic read_all(input string tag);
    int bad;
    logic [9:0] e;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      MAR   = 6'(i);
      RAMWr = 1'b0;
      sb.push_back(mdl[i]);
      tick();
      e = sb.pop_front();
      chk($sformatf("%s[%0d]", tag, i), {6'd0, MDROut}, {6'd0, e});
    end
  endtask

  // Counts cycles with cpu_rst high after rst drops; also notes any ld_done pulse.
  task automatic wait_clear(output int n, output logic saw_done);
    n = 0;
    saw_done = 1'b0;
    while (cpu_rst && n < 200) begin
      if (ld_done) saw_done = 1'b1;
      n++;
      tick();
    end
  endtask

  task automatic start_load(input logic [5:0] mar_v);
    MAR      = mar_v;
    RAMWr    = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    int         n;
    logic       sd;
    logic [9:0] w3 [3];
    w3[0] = 10'h005; w3[1] = 10'h3FF; w3[2] = 10'h1A0;

    rst = 1'b1; MAR = '0; RAMWr = 1'b0; MDRIn = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    tick();
    tick();
    chk("rst_mdrout",   {6'd0, MDROut}, 16'h0);
    chk("rst_ld_ready", {15'd0, ld_ready}, 16'h0);
    chk("rst_cpu_rst",  {15'd0, cpu_rst}, 16'h1);
    chk("rst_ld_done",  {15'd0, ld_done}, 16'h0);
    chk("rst_ld_count", {9'd0, ld_count}, 16'h0);

    rst = 1'b0;
    wait_clear(n, sd);
    chk("clear_len0", 16'(n), 16'd64);

    // Preload through the CPU port, then reset must wipe it.
    for (int i = 0; i < 4; i++) begin
      MAR = 6'(i * 9); MDRIn = 10'(10'h111 + i); RAMWr = 1'b1;
      tick();
    end
    RAMWr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wait_clear(n, sd);
    chk("clear_len1", 16'(n), 16'd64);
    read_all("clr");

    // CPU write then read, then same-edge read/write returns old data.
    MAR = 6'd10; MDRIn = 10'h2AA; RAMWr = 1'b1;
    tick();
    mdl[10] = 10'h2AA;
    rd(6'd10);
    MAR = 6'd10; MDRIn = 10'h155; RAMWr = 1'b1;
    sb.push_back(mdl[10]);
    tick();
    chk("rw_old", {6'd0, MDROut}, {6'd0, sb.pop_front()});
    mdl[10] = 10'h155;
    rd(6'd10);

    // Short load with idle gaps; the CPU port tries to write address 0 throughout.
    start_load(6'd10);
    chk("ld_cpu_rst", {15'd0, cpu_rst}, 16'h1);
    chk("ld_ready",   {15'd0, ld_ready}, 16'h1);
    chk("ld_mdr0",    {6'd0, MDROut}, 16'h0);
    MAR = 6'd0; MDRIn = 10'h3FF; RAMWr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_data = w3[k]; ld_last = (k == 2);
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      mdl[k] = w3[k];
      if (k < 2) begin
        chk($sformatf("ld_gap_mdr%0d", k),  {6'd0, MDROut}, 16'h0);
        chk($sformatf("ld_gap_done%0d", k), {15'd0, ld_done}, 16'h0);
        tick();
        chk($sformatf("ld_idle_mdr%0d", k), {6'd0, MDROut}, 16'h0);
      end
    end
    RAMWr = 1'b0;
    chk("ld_done_pulse", {15'd0, ld_done}, 16'h1);
    chk("ld_cpu_rst_fall", {15'd0, cpu_rst}, 16'h0);
    chk("ld_ready_fall", {15'd0, ld_ready}, 16'h0);
    chk("ld_count3", {9'd0, ld_count}, 16'd3);
    tick();
    chk("ld_done_once", {15'd0, ld_done}, 16'h0);
    read_all("short");

    // Overflow: 70 words offered, only 64 accepted.
    start_load(6'd0);
    for (int k = 0; k < 70; k++) begin
      ld_valid = 1'b1; ld_data = 10'((k * 37 + 3) & 10'h3FF); ld_last = 1'b0;
      if (k < 64) mdl[k] = ld_data;
      if (k == 63) chk("ovf_ready63", {15'd0, ld_ready}, 16'h1);
      if (k == 64) begin
        chk("ovf_ready64", {15'd0, ld_ready}, 16'h0);
        chk("ovf_done",    {15'd0, ld_done}, 16'h1);
      end
      tick();
    end
    ld_valid = 1'b0;
    chk("ovf_count", {9'd0, ld_count}, 16'd64);
    read_all("ovf");

    // Abort after 5 words: reset wipes the partial image and the count.
    start_load(6'd0);
    for (int k = 0; k < 5; k++) begin
      ld_valid = 1'b1; ld_data = 10'(10'h200 + k); ld_last = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("abort_cpu_rst", {15'd0, cpu_rst}, 16'h1);
    chk("abort_ready",   {15'd0, ld_ready}, 16'h0);
    tick();
    rst = 1'b0;
    wait_clear(n, sd);
    chk("abort_clear_len", 16'(n), 16'd64);
    chk("abort_no_done", {15'd0, sd}, 16'h0);
    chk("abort_count", {9'd0, ld_count}, 16'h0);
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    read_all("abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fbcpu_mem.md
# fbcpu_mem

Single-port 64 x 10 program/data memory that responds to the FB-CPU memory bus: the CPU drives MAR/RAMWr/MDRIn and samples MDROut. It also contains a streaming program loader. The loader clears memory after reset, accepts a program image over a valid/ready handshake, and holds the CPU in reset through its own cpu_rst output until the image is in place. It sits between the testbench or top level and the FB-CPU core.

## Interface
- ADDRESS_WIDTH, 6, word address width; depth = 2**ADDRESS_WIDTH (64).
- DATA_WIDTH, 10, word width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- MAR  in  ADDRESS_WIDTH  CPU address.
- RAMWr  in  1  CPU write enable.
- MDRIn  in  DATA_WIDTH  CPU write data.
- MDROut  out  DATA_WIDTH  registered read data to the CPU.
- ld_start  in  1  request a program load; sampled in RUN only.
- ld_valid  in  1  loader word valid.
- ld_data  in  DATA_WIDTH  loader word.
- ld_last  in  1  marks the final loader word; qualified by the handshake.
- ld_ready  out  1  loader can accept a word.
- cpu_rst  out  1  reset to the FB-CPU core, active-high.
- ld_done  out  1  one-cycle pulse when a load completes.
- ld_count  out  ADDRESS_WIDTH+1  words written by the last completed load; 0..64.

## Operation
- States: CLEAR, RUN, LOAD. A pointer ptr (ADDRESS_WIDTH bits) and a word counter are shared by CLEAR and LOAD.
- Reset, any cycle rst=1:
  - state <= CLEAR, ptr <= 0.
  - No memory writes occur.
  - Outputs: MDROut=0, ld_ready=0, cpu_rst=1, ld_done=0, ld_count=0.
- CLEAR:
  - Each cycle writes mem[ptr] <= 0, then ptr++.
  - The write at ptr=63 moves to RUN.
  - CPU port is ignored, MDROut held 0, cpu_rst=1, ld_ready=0.
- RUN: CPU owns the port.
  - Read: MDROut <= mem[MAR] every edge.
  - Write: if RAMWr=1, mem[MAR] <= MDRIn on the same edge.
  - Same-address read and write on one edge returns the old data; the new data is visible on the next edge.
  - cpu_rst=0.
  - ld_start=1 moves to LOAD on the next edge, with ptr <= 0 and the internal counter <= 0.
- LOAD: loader owns the port.
  - cpu_rst=1, ld_ready=1, MDROut held 0.
  - CPU MAR/RAMWr/MDRIn are ignored.
  - On each edge with ld_valid & ld_ready: mem[ptr] <= ld_data, ptr++, counter++.
  - Exit to RUN when the accepted word has ld_last=1, or when it was written at ptr=63 (overflow stop; ld_last is not required).
  - On exit: ld_count <= counter+1, and ld_done=1 for the first RUN cycle.
  - Words beyond the exit are not accepted, because ld_ready=0 in RUN.
  - Unloaded addresses keep their prior contents; only CLEAR zeroes them.
- ld_valid=0 in LOAD: stall indefinitely, no timeout.
- ld_start in CLEAR or LOAD is ignored. ld_start held high in RUN re-enters LOAD on the next edge (level-sensitive).
- rst mid-LOAD or mid-CLEAR: abort immediately and restart CLEAR. The partial image is wiped by the subsequent clear, and ld_count resets to 0.
- Address arithmetic: ptr wraps modulo 64 but never needs to; the exit at 63 prevents wrap.

## Timing
- CLEAR takes exactly 64 cycles after the first edge with rst=0. cpu_rst first reads 0 in the 65th cycle after rst falls.
- Read latency is 1 cycle: MAR presented in cycle N gives MDROut valid in cycle N+1. This matches the CPU fetch: MAR driven in its state 0, IR captured at the end of state 1.
- Write takes effect at the edge where RAMWr=1.
- LOAD to RUN: cpu_rst falls in the same cycle that ld_done pulses. The CPU comes out of reset at PC=0 on the following edge.
- RUN to LOAD: cpu_rst rises in the cycle after ld_start is sampled. ld_ready rises in the same cycle.
- The handshake is accepted only when ld_valid and ld_ready are both 1 at the edge. ld_data and ld_last must be stable while ld_valid=1.

## Test plan
- Reset clear: preload via the CPU port, pulse rst for 2 cycles, wait 64 cycles, then read all 64 addresses -> all 0. cpu_rst is 1 for exactly 64 cycles after rst falls.
- Short load: ld_start, then send words 0x005, 0x3FF, 0x1A0 with ld_last on the third; toggle ld_valid with one idle cycle between words -> mem[0..2] hold those values, ld_count=3, ld_done pulses once, cpu_rst falls with ld_done.
- CPU read/write: in RUN, write 0x2AA to address 10, then read address 10 -> MDROut=0x2AA exactly 1 cycle after MAR=10. A same-edge read+write to address 10 with 0x155 returns 0x2AA first, then 0x155.
- Overflow: send 70 words with no ld_last -> only 64 accepted, ld_ready=0 after the 64th, mem[63]=64th word, ld_count=64.
- Abort: rst asserted after 5 of 10 words loaded -> CLEAR restarts, all memory is 0 after 64 cycles, ld_count=0, no ld_done pulse.
- Isolation: during LOAD, drive RAMWr=1, MAR=0, MDRIn=0x3FF -> mem[0] holds only the loader word; MDROut stays 0 throughout LOAD.
